// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path: segment patterns, digit slots, digit count.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t IDX_H2 = 3'd0;
  localparam digit_idx_t IDX_H1 = 3'd1;
  localparam digit_idx_t IDX_M2 = 3'd2;
  localparam digit_idx_t IDX_M1 = 3'd3;
  localparam digit_idx_t IDX_S2 = 3'd4;
  localparam digit_idx_t IDX_S1 = 3'd5;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/clock_disp_seg7_dec.sv
// BCD to active-high 7-segment decoder; codes 10..15 show a dash. Shared with the alarm display.
module seg7_dec
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed 7-segment scanner with per-frame digit snapshot and blanking gaps.
// Optional leading-zero blanking of the hour-tens digit: define CLOCK_DISP_LZB_EN.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int BLANK_CYC      = 16,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic       colon_on,
  output logic [5:0] com,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [5:0] COM_OFF = (COM_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [DIV_W-1:0]                div_q, div_d;
  digit_idx_t                      idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      sh_q, sh_d;
  logic                            colon_q, colon_d;
  logic [5:0]                      com_q, com_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            dp_q, dp_d;

  logic [3:0] cur_bcd;
  logic [6:0] dec_seg;
  logic [5:0] com_act;
  logic [6:0] seg_act;
  logic       dp_act;

  // Slot timing and frame snapshot; shadow index 0 holds h2 so it lines up with idx.
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    colon_d = colon_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      if (idx_q == IDX_S1) begin
        idx_d   = IDX_H2;
        sh_d    = {s1, s2, m1, m2, h1, h2};
        colon_d = colon_on;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  assign cur_bcd = sh_q[idx_q];

  seg7_dec u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  always_comb begin
    com_act = (div_q >= BLANK_END) ? (6'b100000 >> idx_q) : 6'b000000;
    seg_act = dec_seg;
    dp_act  = colon_q && ((idx_q == IDX_H1) || (idx_q == IDX_M1));
`ifdef CLOCK_DISP_LZB_EN
    if ((idx_q == IDX_H2) && (sh_q[IDX_H2] == 4'd0)) begin
      seg_act = 7'h00;
      dp_act  = 1'b0;
    end
`endif
    com_d = (COM_ACTIVE_LOW != 0) ? ~com_act : com_act;
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_act  : dp_act;
  end

  // Output registers: one cycle behind the (idx, div) state
  always_ff @(posedge in_clk) begin
    if (rst) begin
      div_q   <= '0;
      idx_q   <= IDX_H2;
      sh_q    <= '0;
      colon_q <= 1'b0;
      com_q   <= COM_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      colon_q <= colon_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign com = com_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Scoreboard bench for clock_disp_scan (SCAN_DIV=8, BLANK_CYC=2), plain and inverted-polarity instances.
module tb_clock_disp_scan;

  logic       in_clk;
  logic       rst;
  logic [3:0] h2, h1, m2, m1, s2, s1;
  logic       colon_on;
  logic [5:0] com, com_inv;
  logic [6:0] seg, seg_inv;
  logic       dp, dp_inv;

  int checks = 0;
  int fails  = 0;

`ifdef CLOCK_DISP_LZB_EN
  localparam logic [6:0] H2_ZERO_SEG = 7'h00;
`else
  localparam logic [6:0] H2_ZERO_SEG = 7'h3F;
`endif

  clock_disp_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .COM_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) dut (
    .in_clk(in_clk), .rst(rst), .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
    .colon_on(colon_on), .com(com), .seg(seg), .dp(dp)
  );

  clock_disp_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_inv (
    .in_clk(in_clk), .rst(rst), .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
    .colon_on(colon_on), .com(com_inv), .seg(seg_inv), .dp(dp_inv)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic [5:0] com;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [6:0] segtab(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected output stream: k counts cycles since the last reset edge; a frame is 48 cycles.
  int         k = 0;
  bit         armed = 1'b0;
  logic [3:0] msh [6];
  logic       mcol;

  always @(posedge in_clk) begin : gen
    exp_t e;
    int   slot;
    int   ph;
    if (rst) begin
      armed = 1'b1;
      k     = 0;
      for (int i = 0; i < 6; i++) msh[i] = 4'd0;
      mcol  = 1'b0;
      e     = '0;
      sbq.push_back(e);
    end else if (armed) begin
      slot  = (k / 8) % 6;
      ph    = k % 8;
      e.com = (ph >= 2) ? (6'b100000 >> slot) : 6'b000000;
      e.seg = segtab(msh[slot]);
      e.dp  = mcol && (slot == 1 || slot == 3);
`ifdef CLOCK_DISP_LZB_EN
      if (slot == 0 && msh[0] == 4'd0) begin
        e.seg = 7'h00;
        e.dp  = 1'b0;
      end
`endif
      sbq.push_back(e);
      if (k % 48 == 47) begin
        msh[0] = h2; msh[1] = h1; msh[2] = m2;
        msh[3] = m1; msh[4] = s2; msh[5] = s1;
        mcol   = colon_on;
      end
      k++;
    end
  end

  always @(negedge in_clk) begin : mon
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp("sb_com", {2'b0, com}, {2'b0, e.com});
      cmp("sb_seg", {1'b0, seg}, {1'b0, e.seg});
      cmp("sb_dp", {7'b0, dp}, {7'b0, e.dp});
      cmp("sb_com_onehot0", {7'b0, $onehot0(com)}, 8'd1);
      cmp("sb_inv_com", {2'b0, com_inv}, {2'b0, ~e.com});
      cmp("sb_inv_seg", {1'b0, seg_inv}, {1'b0, ~e.seg});
      cmp("sb_inv_dp", {7'b0, dp_inv}, {7'b0, ~e.dp});
    end
  end

  task automatic wait_state(input int t);
    int n = 0;
    while (!(armed && !rst && k == t + 1) && n < 3000) begin
      @(negedge in_clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      fails++;
      $display("FAIL wait_state: got timeout expected state %0d", t);
    end
  endtask

  task automatic spot(input string nm, input logic [5:0] ec, input logic [6:0] es, input logic ed);
    cmp({nm, "_com"}, {2'b0, com}, {2'b0, ec});
    cmp({nm, "_seg"}, {1'b0, seg}, {1'b0, es});
    cmp({nm, "_dp"}, {7'b0, dp}, {7'b0, ed});
  endtask

  task automatic spot_inv(input string nm, input logic [5:0] ec, input logic [6:0] es, input logic ed);
    cmp({nm, "_com"}, {2'b0, com_inv}, {2'b0, ec});
    cmp({nm, "_seg"}, {1'b0, seg_inv}, {1'b0, es});
    cmp({nm, "_dp"}, {7'b0, dp_inv}, {7'b0, ed});
  endtask

  initial begin
    rst = 1'b1;
    h2 = 4'd1; h1 = 4'd2; m2 = 4'd3; m1 = 4'd4; s2 = 4'd5; s1 = 4'd6;
    colon_on = 1'b0;
    repeat (2) @(posedge in_clk);
    #2 rst = 1'b0;

    // Frame 0: shadows still zero
    wait_state(0);   spot("f0_h2_blank", 6'b000000, H2_ZERO_SEG, 1'b0);
    wait_state(2);   spot("f0_h2_on", 6'b100000, H2_ZERO_SEG, 1'b0);

    // Frame 1: 1,2,3,4,5,6
    wait_state(50);  spot("f1_h2", 6'b100000, 7'h06, 1'b0);
    spot_inv("f1_inv_h2", 6'b011111, 7'h79, 1'b1);
    wait_state(58);
    m1 = 4'd7; s1 = 4'hC; colon_on = 1'b1;
    wait_state(74);  spot("f1_m1_old", 6'b000100, 7'h66, 1'b0);
    wait_state(88);  spot("f1_s1_blank", 6'b000000, 7'h7D, 1'b0);
    wait_state(90);  spot("f1_s1_on", 6'b000001, 7'h7D, 1'b0);

    // Frame 2: new m1, invalid s1, colon
    wait_state(106); spot("f2_h1_dp", 6'b010000, 7'h5B, 1'b1);
    wait_state(114); spot("f2_m2", 6'b001000, 7'h4F, 1'b0);
    wait_state(122); spot("f2_m1_new", 6'b000100, 7'h07, 1'b1);
    wait_state(138); spot("f2_s1_dash", 6'b000001, 7'h40, 1'b0);

    // Frame 3: reset while idx=4
    wait_state(178); spot("f3_s2", 6'b000010, 7'h6D, 1'b0);
    rst = 1'b1;
    @(negedge in_clk);
    spot("rst_mid", 6'b000000, 7'h00, 1'b0);
    spot_inv("rst_mid_inv", 6'b111111, 7'h7F, 1'b1);
    rst = 1'b0;
    h2 = 4'd0;

    wait_state(0);   spot("r0_h2_blank", 6'b000000, H2_ZERO_SEG, 1'b0);
    wait_state(2);   spot("r0_h2_on", 6'b100000, H2_ZERO_SEG, 1'b0);
    wait_state(10);  spot("r0_h1_zero", 6'b010000, 7'h3F, 1'b0);
    wait_state(50);  spot("r1_h2_zero", 6'b100000, H2_ZERO_SEG, 1'b0);
    spot_inv("r1_inv_h2", 6'b011111, ~H2_ZERO_SEG, 1'b1);
    wait_state(58);  spot("r1_h1_dp", 6'b010000, 7'h5B, 1'b1);

    repeat (3) @(negedge in_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
